sar_logic: RTL and testbench

//  Successive-approximation controller for the SAR-ADC model. Sequences sample -> bit-by-bit

---
 rtl/sar_pkg.sv | 23 ++
 rtl/sar_cap_switch.sv | 51 +++++
 rtl/sar_logic.sv | 178 +++++++++++++++++
 tb/tb_sar_logic.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sar_pkg.sv
// Shared types and DAC drive codes for the SAR-ADC controller.
// Used by sar_logic and sar_cap_switch.
package sar_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SAMPLE,
        COMP,
        WAIT,
        DONE
    } sar_state_t;

    // Per-cap {h,l} drive: 00 = vcm, 10 = vrefp, 01 = vrefn; 11 is never produced.
    localparam logic [1:0] DAC_VCM   = 2'b00;
    localparam logic [1:0] DAC_VREFP = 2'b10;
    localparam logic [1:0] DAC_VREFN = 2'b01;

    // DAC above vcm means the trial bit is kept and its cap is pulled down to vrefn.
    function automatic logic [1:0] cap_code(input logic decision);
        return decision ? DAC_VREFN : DAC_VREFP;
    endfunction

endpackage

// File: rtl/sar_cap_switch.sv
// Registered per-capacitor {h,l} select for the capacitor DAC.
// Bit index k (k >= 1) maps to cap ADC_BITS-k, so the MSB decision drives cap 1.
module sar_cap_switch
    import sar_pkg::*;
#(
    parameter int unsigned ADC_BITS = 8,
    parameter int unsigned BIT_W    = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                update,
    input  logic [BIT_W-1:0]    bit_idx,
    input  logic                decision,
    output logic [1:ADC_BITS-1] dac_data_h,
    output logic [1:ADC_BITS-1] dac_data_l
);

    logic [1:ADC_BITS-1] cap_h_q, cap_h_d;
    logic [1:ADC_BITS-1] cap_l_q, cap_l_d;

    always_comb begin
        cap_h_d = cap_h_q;
        cap_l_d = cap_l_q;
        if (clear) begin
            cap_h_d = '0;
            cap_l_d = '0;
        end else if (update) begin
            // Bit 0 matches no cap, so the LSB decision leaves the array untouched.
            for (int j = 1; j < ADC_BITS; j++) begin
                if (bit_idx == BIT_W'(ADC_BITS - j)) begin
                    {cap_h_d[j], cap_l_d[j]} = cap_code(decision);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cap_h_q <= '0;
            cap_l_q <= '0;
        end else begin
            cap_h_q <= cap_h_d;
            cap_l_q <= cap_l_d;
        end
    end

    assign dac_data_h = cap_h_q;
    assign dac_data_l = cap_l_q;

endmodule

// File: rtl/sar_logic.sv
// Successive-approximation controller: sample, MSB-first compare, cap switching, code out.
// Optional comparator-wait timeout is built when SAR_TIMEOUT_EN is defined.
module sar_logic
    import sar_pkg::*;
#(
    parameter int unsigned ADC_BITS       = 8,
    parameter int unsigned SAMPLE_CYCLES  = 2,
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                comp_out,
    input  logic                comp_valid,
    output logic                sample,
    output logic                comp_en,
    output logic [1:ADC_BITS-1] dac_data_h,
    output logic [1:ADC_BITS-1] dac_data_l,
    output logic [ADC_BITS-1:0] dout,
    output logic                dout_valid,
    output logic                busy,
    output logic                timeout_err
);

    localparam int unsigned BIT_W  = $clog2(ADC_BITS);
    localparam int unsigned SCNT_W = $clog2(SAMPLE_CYCLES + 1);

    sar_state_t          state_q, state_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [SCNT_W-1:0]   scnt_q, scnt_d;
    logic [ADC_BITS-1:0] code_q, code_d;
    logic [ADC_BITS-1:0] dout_q, dout_d;

    logic cap_clear;
    logic cap_update;
    logic decide;
    logic decision;

`ifdef SAR_TIMEOUT_EN
    localparam int unsigned TCNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
    logic              terr_q, terr_d;
`endif

    always_comb begin
        state_d    = state_q;
        bit_d      = bit_q;
        scnt_d     = scnt_q;
        code_d     = code_q;
        dout_d     = dout_q;
        cap_clear  = 1'b0;
        cap_update = 1'b0;
        decide     = 1'b0;
        decision   = comp_out;
`ifdef SAR_TIMEOUT_EN
        tcnt_d     = tcnt_q;
        terr_d     = terr_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = SAMPLE;
                    scnt_d    = '0;
                    code_d    = '0;
                    cap_clear = 1'b1;
                end
            end

            SAMPLE: begin
                if (scnt_q == SCNT_W'(SAMPLE_CYCLES - 1)) begin
                    state_d = COMP;
                    bit_d   = BIT_W'(ADC_BITS - 1);
                end else begin
                    scnt_d = scnt_q + 1'b1;
                end
            end

            COMP: begin
                state_d = WAIT;
`ifdef SAR_TIMEOUT_EN
                tcnt_d  = '0;
`endif
            end

            WAIT: begin
                decide = comp_valid;
`ifdef SAR_TIMEOUT_EN
                // A silent comparator resolves as "below vcm" and is flagged until reset.
                if (!comp_valid) begin
                    if (tcnt_q == TCNT_W'(TIMEOUT_CYCLES - 1)) begin
                        decide   = 1'b1;
                        decision = 1'b0;
                        terr_d   = 1'b1;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
`endif
                if (decide) begin
                    code_d[bit_q] = decision;
                    if (bit_q == '0) begin
                        state_d = DONE;
                        dout_d  = code_d;
                    end else begin
                        cap_update = 1'b1;
                        bit_d      = bit_q - 1'b1;
                        state_d    = COMP;
                    end
                end
            end

            DONE: begin
                state_d   = IDLE;
                cap_clear = 1'b1;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            bit_q   <= '0;
            scnt_q  <= '0;
            code_q  <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            scnt_q  <= scnt_d;
            code_q  <= code_d;
            dout_q  <= dout_d;
        end
    end

`ifdef SAR_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            tcnt_q <= '0;
            terr_q <= 1'b0;
        end else begin
            tcnt_q <= tcnt_d;
            terr_q <= terr_d;
        end
    end

    assign timeout_err = terr_q;
`else
    // TIMEOUT_CYCLES only matters when the timeout is built in.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_err        = 1'b0;
`endif

    sar_cap_switch #(
        .ADC_BITS (ADC_BITS),
        .BIT_W    (BIT_W)
    ) u_cap_switch (
        .clk        (clk),
        .reset      (reset),
        .clear      (cap_clear),
        .update     (cap_update),
        .bit_idx    (bit_q),
        .decision   (decision),
        .dac_data_h (dac_data_h),
        .dac_data_l (dac_data_l)
    );

    assign sample     = (state_q == SAMPLE);
    assign comp_en    = (state_q == COMP);
    assign dout_valid = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign dout       = dout_q;

endmodule

// File: tb/tb_sar_logic.sv
// Directed bench for sar_logic: scripted and closed-loop comparator, aborts, stalls, back-to-back.
`timescale 1ns/1ps
module tb_sar_logic;

    localparam int unsigned ADC_BITS = 8;

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic                comp_out;
    logic                comp_valid;
    logic                sample;
    logic                comp_en;
    logic [1:ADC_BITS-1] dac_h;
    logic [1:ADC_BITS-1] dac_l;
    logic [ADC_BITS-1:0] dout;
    logic                dout_valid;
    logic                busy;
    logic                timeout_err;

    int total = 0;
    int bad = 0;
    int edge_cnt = 0;
    int valid_cnt = 0;

    sar_logic #(
        .ADC_BITS       (ADC_BITS),
        .SAMPLE_CYCLES  (2),
        .TIMEOUT_CYCLES (15)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .comp_out    (comp_out),
        .comp_valid  (comp_valid),
        .sample      (sample),
        .comp_en     (comp_en),
        .dac_data_h  (dac_h),
        .dac_data_l  (dac_l),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;
    always @(negedge clk) if (dout_valid) valid_cnt <= valid_cnt + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: observed=no finish required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Ideal cap DAC: cap j moves the output by 2^-(j+1) * (vcap - vcm).
    function automatic logic model_cmp(input real vi, input logic [1:7] h, input logic [1:7] l);
        real v;
        real w;
        v = vi;
        w = 0.25;
        for (int j = 1; j < 8; j++) begin
            if (h[j] && !l[j]) v = v + w * 0.5;
            else if (!h[j] && l[j]) v = v - w * 0.5;
            w = w / 2.0;
        end
        return (v > 0.5);
    endfunction

    // Returns at the negedge inside DONE (or inside WAIT of abort_bit with reset raised).
    task automatic run_conv(input bit send_start, input bit closed, input real vi,
                            input logic [7:0] script, input bit poke, input int abort_bit,
                            output logic [7:0] got, output int lat,
                            output logic [1:7] h_pre, output logic [1:7] l_pre);
        int   e0;
        int   guard;
        logic d;
        got   = '0;
        lat   = -1;
        h_pre = '0;
        l_pre = '0;
        e0    = edge_cnt;
        if (send_start) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        for (int k = ADC_BITS - 1; k >= 0; k--) begin
            guard = 0;
            while (!comp_en && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            if (!comp_en) begin
                check("comp_en_wait", 32'(comp_en), 32'd1);
                return;
            end
            @(negedge clk);
            if (k == abort_bit) begin
                reset = 1'b1;
                return;
            end
            if (closed) d = model_cmp(vi, dac_h, dac_l);
            else d = script[k];
            if (k == 0) begin
                h_pre = dac_h;
                l_pre = dac_l;
            end
            comp_out   = d;
            comp_valid = 1'b1;
            start      = poke;
            @(negedge clk);
            comp_out   = 1'b0;
            comp_valid = 1'b0;
            start      = 1'b0;
        end
        lat   = edge_cnt - e0;
        got   = dout;
        start = poke;
    endtask

    logic [7:0] got;
    int         lat;
    logic [1:7] hp;
    logic [1:7] lp;
    int         vc0;
    int         guard0;

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        comp_out   = 1'b0;
        comp_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sample", 32'(sample), 32'd0);
        check("rst_comp_en", 32'(comp_en), 32'd0);
        check("rst_dout_valid", 32'(dout_valid), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_dac_h", 32'(dac_h), 32'd0);
        check("rst_dac_l", 32'(dac_l), 32'd0);
        check("rst_terr", 32'(timeout_err), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);

        // Scripted decisions 1,0,1,1,0,0,1,0
        run_conv(1'b1, 1'b0, 0.0, 8'b1011_0010, 1'b0, -1, got, lat, hp, lp);
        check("t1_dout_valid", 32'(dout_valid), 32'd1);
        check("t1_dout", 32'(got), 32'hB2);
        check("t1_latency", 32'(lat), 32'd19);
        check("t1_caps_h_pre", 32'(hp), 32'b0100110);
        check("t1_caps_l_pre", 32'(lp), 32'b1011001);
        check("t1_caps_h_done", 32'(dac_h), 32'b0100110);
        check("t1_busy_done", 32'(busy), 32'd1);
        @(negedge clk);
        check("t1_idle_busy", 32'(busy), 32'd0);
        check("t1_idle_dv", 32'(dout_valid), 32'd0);
        check("t1_idle_h", 32'(dac_h), 32'd0);
        check("t1_idle_l", 32'(dac_l), 32'd0);
        check("t1_dout_hold", 32'(dout), 32'hB2);

        // Closed loop against the ideal DAC model
        run_conv(1'b1, 1'b1, 0.501, 8'h00, 1'b0, -1, got, lat, hp, lp);
        check("t2_dout_0p501", 32'(got), 32'h80);
        @(negedge clk);
        run_conv(1'b1, 1'b1, 0.30, 8'h00, 1'b0, -1, got, lat, hp, lp);
        check("t2_dout_0p30", 32'(got), 32'h19);
        check("t2_latency", 32'(lat), 32'd19);
        @(negedge clk);

        // start pulsed mid-conversion and in DONE must be ignored
        vc0 = valid_cnt;
        run_conv(1'b1, 1'b0, 0.0, 8'h5A, 1'b1, -1, got, lat, hp, lp);
        check("t3_dout", 32'(got), 32'h5A);
        check("t3_latency", 32'(lat), 32'd19);
        @(negedge clk);
        start = 1'b0;
        check("t3_idle_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        check("t3_still_idle", 32'(busy), 32'd0);
        check("t3_valid_pulses", 32'(valid_cnt - vc0), 32'd1);
        check("t3_dout_hold", 32'(dout), 32'h5A);

        // Back-to-back: start raised in the first IDLE cycle
        run_conv(1'b1, 1'b0, 0.0, 8'h3C, 1'b0, -1, got, lat, hp, lp);
        check("t6_first_dout", 32'(got), 32'h3C);
        @(negedge clk);
        check("t6_idle_busy", 32'(busy), 32'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t6_sample", 32'(sample), 32'd1);
        check("t6_sample_h", 32'(dac_h), 32'd0);
        check("t6_sample_l", 32'(dac_l), 32'd0);
        run_conv(1'b0, 1'b0, 0.0, 8'hC3, 1'b0, -1, got, lat, hp, lp);
        check("t6_second_dout", 32'(got), 32'hC3);
        @(negedge clk);

        // Comparator stall in WAIT of the MSB
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        guard0 = 0;
        while (!comp_en && guard0 < 50) begin
            @(negedge clk);
            guard0++;
        end
        check("t5_comp_en_seen", 32'(comp_en), 32'd1);
        repeat (40) @(negedge clk);
`ifdef SAR_TIMEOUT_EN
        check("t5_terr_set", 32'(timeout_err), 32'd1);
        check("t5_busy", 32'(busy), 32'd1);
`else
        check("t5_busy", 32'(busy), 32'd1);
        check("t5_comp_en_low", 32'(comp_en), 32'd0);
        check("t5_no_valid", 32'(dout_valid), 32'd0);
        check("t5_terr_zero", 32'(timeout_err), 32'd0);
`endif
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t5_rst_terr", 32'(timeout_err), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_dout", 32'(dout), 32'd0);
        @(negedge clk);

        // Reset in WAIT of bit 4 after decisions 1,0,1 on bits 7..5
        vc0 = valid_cnt;
        run_conv(1'b1, 1'b0, 0.0, 8'b1010_0000, 1'b0, 4, got, lat, hp, lp);
        check("t4_mid_h", 32'(dac_h), 32'b0100000);
        check("t4_mid_l", 32'(dac_l), 32'b1010000);
        @(negedge clk);
        reset = 1'b0;
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_h", 32'(dac_h), 32'd0);
        check("t4_l", 32'(dac_l), 32'd0);
        check("t4_dout", 32'(dout), 32'd0);
        check("t4_dv", 32'(dout_valid), 32'd0);
        repeat (3) @(negedge clk);
        check("t4_no_pulse", 32'(valid_cnt - vc0), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
